// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, clear-engine state type and default geometry for regfile_mp
package regfile_pkg;

  localparam int DEF_LOG_REG_CNT           = 4;
  localparam int DEF_LOG_SUPERSCALAR_WIDTH = 4;
  localparam int DEF_REG_WIDTH             = 288;
  localparam int DEF_NUM_RD                = 2;
  localparam int DEF_NUM_WR                = 2;

  function automatic int calc_addr_w(input int log_reg_cnt, input int log_superscalar_width);
    return log_reg_cnt + log_superscalar_width;
  endfunction

  localparam int DEF_ADDR_W = calc_addr_w(DEF_LOG_REG_CNT, DEF_LOG_SUPERSCALAR_WIDTH);

  typedef logic [DEF_ADDR_W-1:0]    addr_t;
  typedef logic [DEF_REG_WIDTH-1:0] data_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: finds the winning enabled write port for one address (highest index wins)
module regfile_wr_arbiter #(
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 1
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  output logic                          hit,
  output logic [SEL_W-1:0]              sel
);

  // ascending scan so the last (highest-indexed) match overrides earlier ones
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j] && wr_addr[j] == addr) begin
        hit = 1'b1;
        sel = SEL_W'(j);
      end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with sequential clear engine; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  LOG_REG_CNT           = DEF_LOG_REG_CNT,
  parameter int  LOG_SUPERSCALAR_WIDTH = DEF_LOG_SUPERSCALAR_WIDTH,
  parameter int  REG_WIDTH             = DEF_REG_WIDTH,
  parameter int  NUM_RD                = DEF_NUM_RD,
  parameter int  NUM_WR                = DEF_NUM_WR,
  localparam int ADDR_W                = calc_addr_w(LOG_REG_CNT, LOG_SUPERSCALAR_WIDTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             freeze,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD-1:0][REG_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][REG_WIDTH-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SEL_W = NUM_WR > 1 ? $clog2(NUM_WR) : 1;

  clr_state_t                       state_q, state_d;
  logic [ADDR_W-1:0]                clr_ptr_q, clr_ptr_d;
  logic [NUM_RD-1:0][REG_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [REG_WIDTH-1:0]             mem_q [DEPTH];
  logic [REG_WIDTH-1:0]             mem_d [DEPTH];
  logic [DEPTH-1:0]                 wr_hit;
  logic [SEL_W-1:0]                 wr_sel [DEPTH];
  logic                             run_idle, run_clear;

  assign run_idle  = state_q == IDLE && !freeze;
  assign run_clear = state_q == CLEAR && !freeze;
  assign busy      = state_q == CLEAR;
  assign rd_data   = rd_data_q;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    regfile_wr_arbiter #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_arb (
      .addr   (ADDR_W'(e)),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .hit    (wr_hit[e]),
      .sel    (wr_sel[e])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic [NUM_RD-1:0] rd_hit;
  logic [SEL_W-1:0]  rd_sel [NUM_RD];
  for (genvar i = 0; i < NUM_RD; i++) begin : g_byp
    regfile_wr_arbiter #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_arb (
      .addr   (rd_addr[i]),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .hit    (rd_hit[i]),
      .sel    (rd_sel[i])
    );
  end
`endif

  // clear sweep zeroes the pointed entry; otherwise the winning write port updates each entry
  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      mem_d[e] = run_clear && clr_ptr_q == ADDR_W'(e) ? '0 :
                 run_idle && wr_hit[e] ? wr_data[wr_sel[e]] : mem_q[e];
  end

  // read registers: hold on freeze, zero during clear, otherwise array (or bypassed write) data
  always_comb begin
    for (int i = 0; i < NUM_RD; i++)
`ifdef REGFILE_BYPASS_EN
      rd_data_d[i] = freeze ? rd_data_q[i] : state_q == CLEAR ? '0 :
                     rd_hit[i] ? wr_data[rd_sel[i]] : mem_q[rd_addr[i]];
`else
      rd_data_d[i] = freeze ? rd_data_q[i] : state_q == CLEAR ? '0 : mem_q[rd_addr[i]];
`endif
  end

  // clear engine: start on request from idle, step the pointer, stop after the last entry
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (run_idle && clear_req) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else if (run_clear) begin
      state_d   = &clr_ptr_q ? IDLE : CLEAR;
      clr_ptr_d = &clr_ptr_q ? clr_ptr_q : clr_ptr_q + 1'b1;
    end
  end

  // storage has no reset; the sweep that follows reset provides the defined contents
  always_ff @(posedge clk) mem_q <= mem_d;

  // control and read-register state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven checks of regfile_mp (reads, writes, conflicts, freeze, clear sweep)
module tb_regfile_mp;

  localparam int AW = 8;
  localparam int W  = 288;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk, reset, freeze, clear_req, busy;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0][W-1:0]    rd_data;
  logic [1:0]           wr_en;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][W-1:0]    wr_data;

  int errors = 0;
  int checks = 0;

  regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .freeze   (freeze),
    .clear_req(clear_req),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    en;
    logic [AW-1:0] wa0, wa1;
    logic [W-1:0]  wd0, wd1;
    logic [AW-1:0] ra0, ra1;
    logic [W-1:0]  e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] en, input logic [AW-1:0] wa0, input logic [W-1:0] wd0,
                              input logic [AW-1:0] wa1, input logic [W-1:0] wd1,
                              input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                              input logic [W-1:0] e0, input logic [W-1:0] e1);
    vec_t v;
    v.en = en; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // counts busy cycles until the sweep ends, optionally freezing and pulsing clear_req at given cycles
  task automatic count_busy(input int fa, input int fl, input int ca, output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      freeze    = n >= fa && n < fa + fl;
      clear_req = n == ca;
      step();
    end
    freeze    = 1'b0;
    clear_req = 1'b0;
  endtask

  vec_t         vecs [12];
  logic [W-1:0] big;
  int           n;

  initial begin
    big = {32'hDEADBEEF, 224'h0, 32'h12345678};
    vecs[0]  = mk(2'b01, 15, 2,     0,  0,     14, 15,  0, BYP ? 2 : 0);
    vecs[1]  = mk(2'b00, 0,  0,     0,  0,     14, 15,  0, 2);
    vecs[2]  = mk(2'b11, 9,  'hAA,  9,  'hBB,  9,  15,  BYP ? 'hBB : 0, 2);
    vecs[3]  = mk(2'b00, 0,  0,     0,  0,     9,  9,   'hBB, 'hBB);
    vecs[4]  = mk(2'b11, 30, 'h11,  31, 'h22,  30, 31,  BYP ? 'h11 : 0, BYP ? 'h22 : 0);
    vecs[5]  = mk(2'b00, 0,  0,     0,  0,     30, 31,  'h11, 'h22);
    vecs[6]  = mk(2'b01, 20, 9,     0,  0,     20, 15,  BYP ? 9 : 0, 2);
    vecs[7]  = mk(2'b00, 0,  0,     0,  0,     20, 9,   9, 'hBB);
    vecs[8]  = mk(2'b10, 0,  0,     255, big,  0,  255, 0, BYP ? big : '0);
    vecs[9]  = mk(2'b00, 0,  0,     0,  0,     0,  255, 0, big);
    vecs[10] = mk(2'b01, 9,  'hCC,  9,  'hDD,  9,  255, BYP ? 'hCC : 'hBB, big);
    vecs[11] = mk(2'b00, 0,  0,     0,  0,     9,  9,   'hCC, 'hCC);

    reset = 1'b1; freeze = 1'b0; clear_req = 1'b0;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    step();
    check("rst_rd0", rd_data[0], '0);
    check("rst_rd1", rd_data[1], '0);
    check("rst_busy", busy, 1);

    reset = 1'b0;
    rd_addr[0] = 200;
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 7;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      step();
      if (n == 10) check("sweep_rd200", rd_data[0], '0);
    end
    wr_en = '0;
    check("reset_sweep_len", n, 256);
    rd_addr[0] = 5;
    step();
    check("sweep_write_blocked", rd_data[0], '0);

    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].en;
      wr_addr[0] = vecs[i].wa0; wr_data[0] = vecs[i].wd0;
      wr_addr[1] = vecs[i].wa1; wr_data[1] = vecs[i].wd1;
      rd_addr[0] = vecs[i].ra0; rd_addr[1] = vecs[i].ra1;
      step();
      check($sformatf("vec%0d_rd0", i), rd_data[0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), rd_data[1], vecs[i].e1);
    end
    wr_en = '0;

    rd_addr[0] = 15;
    step();
    check("pre_freeze_rd", rd_data[0], 2);
    freeze = 1'b1;
    rd_addr[0] = 3;
    wr_en = 2'b01; wr_addr[0] = 3; wr_data[0] = 4;
    step();
    check("freeze_hold1", rd_data[0], 2);
    step();
    check("freeze_hold2", rd_data[0], 2);
    freeze = 1'b0;
    wr_en = '0;
    step();
    check("freeze_write_blocked", rd_data[0], '0);

    wr_en = 2'b01; wr_addr[0] = 1; wr_data[0] = 5;
    step();
    wr_en = '0;
    rd_addr[0] = 1;
    step();
    check("pre_clear_rd1", rd_data[0], 5);
    check("pre_clear_idle", busy, 0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clear_busy_rise", busy, 1);
    count_busy(50, 10, 120, n);
    check("clear_sweep_len_frozen", n, 266);
    rd_addr[0] = 1;
    step();
    check("post_clear_rd1", rd_data[0], '0);

    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 99; i++) step();
    check("midsweep_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(0, 0, 0, n);
    check("restart_sweep_len", n, 256);
    rd_addr[0] = 15;
    step();
    check("post_restart_rd15", rd_data[0], '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
